// File: rtl/proc_hier.sv
// proc_hier: single-cycle 16-bit WISC-subset core with commit-trace outputs
module proc_hier #(
  parameter int    MEM_AW    = 8,
  parameter string IMEM_FILE = "loadfile_all.img"
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] pc,
  output logic [15:0] inst,
  output logic        reg_write,
  output logic [2:0]  write_reg,
  output logic [15:0] write_data,
  output logic        mem_read,
  output logic        mem_write,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_in,
  output logic [15:0] mem_data_out,
  output logic        halt,
  output logic [31:0] cycle_count
);
  localparam int DEPTH = 2 ** MEM_AW;
  logic [15:0] imem [DEPTH];
  logic [15:0] dmem [DEPTH];
  logic [15:0] regs [8];
  logic [15:0] pc_reg;
  logic        halted;
  logic [4:0]  opcode;
  logic [15:0] rs_val, rt_val, imm5, imm8, disp11, eff_addr, load_data, alu_res, seq_pc, next_pc;
  logic        active, is_halt, is_addi, is_subi, is_lbi, is_st, is_ld, is_alu, is_beqz, is_j;
  assign inst      = imem[pc_reg[MEM_AW:1]];
  assign opcode    = inst[15:11];
  assign rs_val    = regs[inst[10:8]];
  assign rt_val    = regs[inst[7:5]];
  assign imm5      = {{11{inst[4]}}, inst[4:0]};
  assign imm8      = {{8{inst[7]}}, inst[7:0]};
  assign disp11    = {{5{inst[10]}}, inst[10:0]};
  assign eff_addr  = rs_val + imm5;
  assign load_data = dmem[eff_addr[MEM_AW:1]];
  assign is_halt = opcode == 5'b00000;
  assign is_addi = opcode == 5'b01000;
  assign is_subi = opcode == 5'b01001;
  assign is_lbi  = opcode == 5'b11000;
  assign is_st   = opcode == 5'b10000;
  assign is_ld   = opcode == 5'b10001;
  assign is_alu  = opcode == 5'b11011;
  assign is_beqz = opcode == 5'b01100;
  assign is_j    = opcode == 5'b00100;
  assign active  = rst & ~halted;
  assign alu_res = inst[1:0] == 2'b00 ? rs_val + rt_val :
                   inst[1:0] == 2'b01 ? rt_val - rs_val :
                   inst[1:0] == 2'b10 ? rs_val ^ rt_val : rs_val & ~rt_val;
  assign seq_pc  = pc_reg + 16'd2;
  assign next_pc = is_j ? seq_pc + disp11 :
                   (is_beqz && rs_val == 16'd0) ? seq_pc + imm8 : seq_pc;
  assign pc           = pc_reg;
  assign reg_write    = active & (is_addi | is_subi | is_lbi | is_ld | is_alu);
  assign write_reg    = is_lbi ? inst[10:8] : is_alu ? inst[4:2] : inst[7:5];
  assign write_data   = is_addi ? rs_val + imm5 :
                        is_subi ? imm5 - rs_val :
                        is_lbi  ? imm8 :
                        is_ld   ? load_data : alu_res;
  assign mem_read     = active & is_ld;
  assign mem_write    = active & is_st;
  assign mem_addr     = eff_addr;
  assign mem_data_in  = rt_val;
  assign mem_data_out = load_data;
  assign halt         = rst & (halted | is_halt);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_reg <= '0;
      halted <= 1'b0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (!halted) begin
      halted <= is_halt;
      pc_reg <= is_halt ? pc_reg : next_pc;
      if (reg_write) regs[write_reg] <= write_data;
    end
  end
  always_ff @(posedge clk) begin
    if (mem_write) dmem[eff_addr[MEM_AW:1]] <= rt_val;
  end
`ifdef CYCLE_COUNT_EN
  logic [31:0] cycle_cnt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cycle_cnt <= '0;
    else if (!halted) cycle_cnt <= cycle_cnt + 32'd1;
  end
  assign cycle_count = cycle_cnt;
`else
  assign cycle_count = '0;
`endif
endmodule

// File: tb/tb_proc_hier.sv
// tb_proc_hier: directed programs preloaded into imem; checks the commit trace cycle by cycle.
module tb_proc_hier;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] pc, inst, writeData, memAddr, memDataIn, memDataOut;
    logic [2:0]  writeReg;
    logic        regWrite, memRead, memWrite, halt;
    logic [31:0] cycleCount;

    int errors = 0;
    int checks = 0;
    logic [15:0] prog [$];

`ifdef CYCLE_COUNT_EN
    localparam bit CC_EN = 1'b1;
`else
    localparam bit CC_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    proc_hier #(.IMEM_FILE("")) dut (
        .clk(clk), .rst(rst), .pc(pc), .inst(inst),
        .reg_write(regWrite), .write_reg(writeReg), .write_data(writeData),
        .mem_read(memRead), .mem_write(memWrite), .mem_addr(memAddr),
        .mem_data_in(memDataIn), .mem_data_out(memDataOut),
        .halt(halt), .cycle_count(cycleCount)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Hold reset, verify cleared state and quiet strobes, load prog, release.
    task automatic start();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_pc", pc, 0);
        check("rst_halt", halt, 0);
        check("rst_rw", regWrite, 0);
        check("rst_mw", memWrite, 0);
        check("rst_mr", memRead, 0);
        check("rst_cc", cycleCount, 0);
        for (int i = 0; i < 256; i++) dut.imem[i] = 16'h0000;
        for (int i = 0; i < prog.size(); i++) dut.imem[i] = prog[i];
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    initial begin
        logic [15:0] v;
        // LBI R1,5; ADDI R2,R1,-1; HALT
        prog = '{16'hC105, 16'h415F, 16'h0000};
        start();
        check("p1_c0_rw", regWrite, 1);
        check("p1_c0_wr", writeReg, 1);
        check("p1_c0_wd", writeData, 16'h0005);
        step();
        check("p1_c1_wr", writeReg, 2);
        check("p1_c1_wd", writeData, 16'h0004);
        step();
        check("p1_halt", halt, 1);
        check("p1_pc", pc, 16'h0004);
        step();
        step();
        check("p1_halt_hold", halt, 1);
        check("p1_pc_hold", pc, 16'h0004);
        check("p1_rw_halted", regWrite, 0);
        check("p1_cc", cycleCount, CC_EN ? 32'd3 : 32'd0);
        step();
        check("p1_cc_frozen", cycleCount, CC_EN ? 32'd3 : 32'd0);

        // LBI R1,0x10; LBI R2,0x7F; ST R2,R1,2; LD R3,R1,2; HALT
        prog = '{16'hC110, 16'hC27F, 16'h8142, 16'h8962, 16'h0000};
        start();
        step();
        step();
        check("st_mw", memWrite, 1);
        check("st_mr", memRead, 0);
        check("st_rw", regWrite, 0);
        check("st_addr", memAddr, 16'h0012);
        check("st_data", memDataIn, 16'h007F);
        step();
        check("ld_mr", memRead, 1);
        check("ld_mw", memWrite, 0);
        check("ld_addr", memAddr, 16'h0012);
        check("ld_dout", memDataOut, 16'h007F);
        check("ld_wr", writeReg, 3);
        check("ld_wd", writeData, 16'h007F);

        // LBI R1,3; LBI R2,5; ADD/SUB/XOR/ANDN R4
        prog = '{16'hC103, 16'hC205, 16'hD950, 16'hD951, 16'hD952, 16'hD953, 16'h0000};
        start();
        step();
        step();
        check("add_wr", writeReg, 4);
        check("add_wd", writeData, 16'h0008);
        step();
        check("sub_wd", writeData, 16'h0002);
        step();
        check("xor_wd", writeData, 16'h0006);
        step();
        check("andn_wd", writeData, 16'h0002);

        // BEQZ R0,+4 taken; NOP at 6; J -2 at 8 loops
        prog = '{16'h6004, 16'h0000, 16'h0000, 16'h0800, 16'h27FE};
        start();
        check("bz_pc0", pc, 16'h0000);
        step();
        check("bz_taken", pc, 16'h0006);
        step();
        check("j_pc", pc, 16'h0008);
        step();
        check("j_loop1", pc, 16'h0008);
        step();
        check("j_loop2", pc, 16'h0008);
        check("j_nohalt", halt, 0);

        // LBI R1,1; BEQZ R1,+4 not taken
        prog = '{16'hC101, 16'h6104, 16'h0800, 16'h0000};
        start();
        step();
        check("bnz_pc", pc, 16'h0002);
        step();
        check("bnz_fall", pc, 16'h0004);

        // Doubling wrap to 0x8000, SUBI to 0x7FFF, ADDI +1 to 0x8000, unknown opcode
        prog = '{16'hC180, 16'hD924, 16'hD924, 16'hD924, 16'hD924, 16'hD924, 16'hD924,
                 16'hD924, 16'hD924, 16'h495F, 16'h4261, 16'h1800, 16'h0000};
        start();
        check("ovf_lbi", writeData, 16'hFF80);
        v = 16'hFF80;
        for (int k = 1; k <= 8; k++) begin
            step();
            v = v + v;
            check($sformatf("ovf_dbl%0d", k), writeData, v);
        end
        step();
        check("ovf_subi", writeData, 16'h7FFF);
        step();
        check("ovf_addi_wr", writeReg, 3);
        check("ovf_addi", writeData, 16'h8000);
        step();
        check("unk_rw", regWrite, 0);
        check("unk_mw", memWrite, 0);
        check("unk_mr", memRead, 0);
        check("unk_halt", halt, 0);
        step();
        check("unk_next_pc", pc, 16'h0018);
        check("unk_then_halt", halt, 1);

        // ADDI R2,R1,1; LBI R1,5; ADDI R2,R1,1; HALT with mid-program reset
        prog = '{16'h4141, 16'hC105, 16'h4141, 16'h0000};
        start();
        check("rr_c0", writeData, 16'h0001);
        step();
        check("rr_c1", writeData, 16'h0005);
        step();
        check("rr_c2", writeData, 16'h0006);
        rst = 1'b0;
        #1;
        check("rr_pc_clr", pc, 16'h0000);
        check("rr_halt_clr", halt, 0);
        check("rr_rw_clr", regWrite, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rr2_c0", writeData, 16'h0001);
        check("rr2_c0_rw", regWrite, 1);
        step();
        check("rr2_c1", writeData, 16'h0005);
        step();
        check("rr2_c2", writeData, 16'h0006);
        step();
        check("rr2_halt", halt, 1);
        check("rr2_pc", pc, 16'h0006);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
